sprite_blitter: RTL
===================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port hires, input, 1 bit: 0 = 64x32 field, 4 words/row; 1 = 128x64 field, 8 words/row.
REQ-004 SHALL have port start, input, 1 bit: draw request, sampled only in IDLE.
REQ-005 SHALL have port clear, input, 1 bit: framebuffer clear request, sampled only in IDLE.
REQ-006 SHALL have port x, input, 8 bits: sprite left column (Vx).
REQ-007 SHALL have port y, input, 8 bits: sprite top row (Vy).
REQ-008 SHALL have port n, input, 4 bits: sprite row count; 0 selects a 16x16 sprite in hires.
REQ-009 SHALL have port spriteAddr, input, 12 bits: memory address of the first sprite byte (I).
REQ-010 SHALL have ports memAddr (output, 12 bits) and memData (input, 8 bits): sprite memory read port, data valid 1 cycle after address.
REQ-011 SHALL have ports fbAddr (output, 9 bits), fbRdData (input, 16 bits), fbWrData (output, 16 bits) and fbWe (output, 1 bit): framebuffer port, read data valid 1 cycle after address; MSB = leftmost pixel.
REQ-012 SHALL have ports busy (output, 1 bit), done (output, 1-cycle pulse) and collision (output, 1 bit).

Function
REQ-013 SHALL latch all request inputs on acceptance; when start and clear are both high in IDLE, clear SHALL win.
REQ-014 SHALL ignore start and clear while busy.
REQ-015 SHALL wrap the origin: xs = x mod width, ys = y mod height (width/height 64/32 or 128/64).
REQ-016 SHALL clip pixels beyond the right or bottom edge, with no wrap of the sprite body.
REQ-017 SHALL take rows = n in lowres or when n != 0; rows = 16 with 16-px width for hires with n = 0; lowres with n = 0 SHALL draw nothing and pulse done 1 cycle after acceptance.
REQ-018 SHALL form each row pattern P (16 bits) as {byte,8'h00} for narrow sprites and {byte0,byte1} for wide sprites; sprite bytes are sequential from spriteAddr.
REQ-019 SHALL compute M = {P,16'h0} >> xs[3:0], with mask0 = M[31:16] and mask1 = M[15:0].
REQ-020 SHALL address word0 as fbAddr = ys_row*wordsPerRow + xs[7:4]; word1 is word0+1.
REQ-021 SHALL skip word1 when it is clipped (xs[7:4] is the last word of the row) or when mask1 == 0.
REQ-022 SHALL use the state sequence FETCH_A (drive memAddr) -> FETCH_B (capture byte0; wide: drive next address) -> [FETCH_C capture byte1, wide only] -> RD0 (drive fbAddr) -> WR0 (fbWe=1, fbWrData = fbRdData ^ mask0) -> [RD1 -> WR1 for word1] -> next row or DONE.
REQ-023 SHALL give a per-row cost of 4 cycles plus 1 if wide plus 2 if word1 is written.
REQ-024 SHALL set collision if any (fbRdData & mask) != 0 on a write; collision SHALL clear on draw acceptance and hold until the next accepted start or clear.
REQ-025 SHALL end the draw after the last row or when the next row reaches the field height, whichever occurs first.
REQ-026 SHALL assert done for exactly 1 cycle in DONE, with busy falling in the same cycle, then return to IDLE.
REQ-027 SHALL run clear as a write of 16'h0000 to addresses 0..511, one per cycle, independent of hires, then enter DONE; clear SHALL set collision to 0.
REQ-028 SHALL assert fbWe only in WR0, WR1 and clear cycles.
REQ-029 SHALL keep busy high from the cycle after acceptance through DONE.

Reset
REQ-030 SHALL, on reset assertion, immediately set: state IDLE, busy=0, done=0, collision=0, fbWe=0, fbAddr=0, memAddr=0, fbWrData=0.
REQ-031 SHALL abort any in-progress draw or clear on reset, leaving already-written words unchanged and performing no further writes.

Verification
REQ-032 SHALL pass: lowres, fb zero, x=3, y=2, n=1, byte 8'hF0 -> single write addr 8 = 16'h1E00, word1 skipped, collision=0, done 4 cycles after FETCH_A.
REQ-033 SHALL pass: repeat the REQ-032 draw -> addr 8 = 16'h0000, collision=1.
REQ-034 SHALL pass: lowres x=60, y=0, n=1, byte 8'hFF -> addr 3 ^= 16'h000F only; word1 (16'hF000) clipped.
REQ-035 SHALL pass: lowres x=70, y=30, n=5 -> origin (6,30); only rows 30, 31 drawn (addr 120, 124); exactly 2 sprite reads.
REQ-036 SHALL pass: hires n=0, x=16, y=0, bytes 16'hFFFF -> 16 writes at addr 1, 9, ..., 121, each 16'hFFFF, none to word1.
REQ-037 SHALL pass: clear -> 512 writes of 16'h0000 to addr 0..511; reset asserted at write 100 -> busy=0 at once, addr 100..511 untouched.

Source files
------------

// File: rtl/sprite_blitter_if.sv
// Sprite-memory read port and framebuffer read/write port of the sprite blitter.
// The blitter is the master; the memories (or the bench) sit on the slave side.
interface sprite_blitter_if;
  logic [11:0] memAddr;
  logic [7:0]  memData;
  logic [8:0]  fbAddr;
  logic [15:0] fbRdData;
  logic [15:0] fbWrData;
  logic        fbWe;

  modport master (
    output memAddr, fbAddr, fbWrData, fbWe,
    input  memData, fbRdData
  );

  modport slave (
    input  memAddr, fbAddr, fbWrData, fbWe,
    output memData, fbRdData
  );
endinterface

// File: rtl/sprite_blitter.sv
// XOR sprite blitter for a 64x32 / 128x64 monochrome framebuffer of 16-bit words,
// with collision detection and a full-framebuffer clear.
module sprite_blitter (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hires,
  input  logic                    start,
  input  logic                    clear,
  input  logic [7:0]              x,
  input  logic [7:0]              y,
  input  logic [3:0]              n,
  input  logic [11:0]             spriteAddr,
  sprite_blitter_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    collision
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_RD0,
    S_WR0,
    S_RD1,
    S_WR1,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        hires_q;
  logic        wide_q;
  logic        busy_q;
  logic        done_q;
  logic        coll_q;
  logic        fbWe_q;
  logic [7:0]  xs_q;
  logic [7:0]  row_q;
  logic [4:0]  rows_left_q;
  logic [15:0] pat_q;
  logic [11:0] memAddr_q;
  logic [8:0]  fbAddr_q;

  logic [7:0]  xs_d;
  logic [7:0]  ys_d;
  logic        wide_d;
  logic [4:0]  rows_d;
  logic [31:0] shifted;
  logic [15:0] mask0;
  logic [15:0] mask1;
  logic [15:0] wr_mask;
  logic        hit;
  logic        last_word;
  logic        take_w1;
  logic [8:0]  word0;
  logic [7:0]  row_next;
  logic        last_row;

  always_comb begin
    // Origin wraps to the field; the sprite body itself is clipped, not wrapped.
    xs_d     = x & (hires ? 8'h7F : 8'h3F);
    ys_d     = y & (hires ? 8'h3F : 8'h1F);
    wide_d   = hires && (n == 4'd0);
    rows_d   = wide_d ? 5'd16 : {1'b0, n};
    shifted  = {pat_q, 16'h0000} >> xs_q[3:0];
    mask0    = shifted[31:16];
    mask1    = shifted[15:0];
    wr_mask  = (state_q == S_WR1) ? mask1 : mask0;
    hit      = |(bus.fbRdData & wr_mask);
    last_word = hires_q ? (xs_q[7:4] == 4'd7) : (xs_q[7:4] == 4'd3);
    take_w1  = !last_word && (mask1 != '0);
    word0    = (hires_q ? {row_q[5:0], 3'b000} : {row_q[6:0], 2'b00}) + {5'b00000, xs_q[7:4]};
    row_next = row_q + 8'd1;
    last_row = (rows_left_q == 5'd1) || (row_next == (hires_q ? 8'd64 : 8'd32));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hires_q     <= 1'b0;
      wide_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coll_q      <= 1'b0;
      fbWe_q      <= 1'b0;
      xs_q        <= '0;
      row_q       <= '0;
      rows_left_q <= '0;
      pat_q       <= '0;
      memAddr_q   <= '0;
      fbAddr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (clear) begin
            coll_q   <= 1'b0;
            fbAddr_q <= '0;
            fbWe_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_CLEAR;
          end else if (start) begin
            coll_q      <= 1'b0;
            hires_q     <= hires;
            wide_q      <= wide_d;
            xs_q        <= xs_d;
            row_q       <= ys_d;
            rows_left_q <= rows_d;
            memAddr_q   <= spriteAddr;
            if (rows_d == 5'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_FETCH_A;
            end
          end
        end
        S_FETCH_A: begin
          if (wide_q) memAddr_q <= memAddr_q + 12'd1;
          state_q <= S_FETCH_B;
        end
        S_FETCH_B: begin
          pat_q <= {bus.memData, 8'h00};
          if (wide_q) begin
            state_q <= S_FETCH_C;
          end else begin
            fbAddr_q <= word0;
            state_q  <= S_RD0;
          end
        end
        S_FETCH_C: begin
          pat_q[7:0] <= bus.memData;
          fbAddr_q   <= word0;
          state_q    <= S_RD0;
        end
        S_RD0: begin
          fbWe_q  <= 1'b1;
          state_q <= S_WR0;
        end
        S_WR0: begin
          fbWe_q <= 1'b0;
          if (hit) coll_q <= 1'b1;
          if (take_w1) begin
            fbAddr_q <= fbAddr_q + 9'd1;
            state_q  <= S_RD1;
          end else if (last_row) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q       <= row_next;
            rows_left_q <= rows_left_q - 5'd1;
            memAddr_q   <= memAddr_q + 12'd1;
            state_q     <= S_FETCH_A;
          end
        end
        S_RD1: begin
          fbWe_q  <= 1'b1;
          state_q <= S_WR1;
        end
        S_WR1: begin
          fbWe_q <= 1'b0;
          if (hit) coll_q <= 1'b1;
          if (last_row) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q       <= row_next;
            rows_left_q <= rows_left_q - 5'd1;
            memAddr_q   <= memAddr_q + 12'd1;
            state_q     <= S_FETCH_A;
          end
        end
        S_CLEAR: begin
          if (fbAddr_q == 9'd511) begin
            fbWe_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            fbAddr_q <= fbAddr_q + 9'd1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write data must follow the read data of the same cycle, so it is the one unregistered output.
  assign bus.fbWrData = (fbWe_q && (state_q != S_CLEAR)) ? (bus.fbRdData ^ wr_mask) : '0;
  assign bus.fbWe     = fbWe_q;
  assign bus.fbAddr   = fbAddr_q;
  assign bus.memAddr  = memAddr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign collision    = coll_q;

endmodule
